// File: rtl/sb_config_loader_if.sv
// Valid/ready stream carrying switch-box configuration words from the bitstream controller.
// The master drives words, the loader (slave) answers with cfg_ready.
interface sb_config_loader_if #(
  parameter int CFG_W = 9
);
  logic [CFG_W-1:0] cfg_word;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (output cfg_word, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/sb_config_loader.sv
// Shadow-banked switch-box configuration loader: a full legal frame commits atomically to sb_config_o.
// Optional legality checker enabled by defining SB_CFG_CHECK_EN.
module sb_config_loader #(
  parameter int NUM_SB = 4,
  parameter int CFG_W  = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        abort_i,
  sb_config_loader_if.slave           cfg_if,
  output logic [NUM_SB*CFG_W-1:0]     sb_config_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [$clog2(NUM_SB)-1:0]   err_index_o
);

  localparam int                 IDX_W = $clog2(NUM_SB);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NUM_SB - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               count_q, count_d;
  logic [NUM_SB-1:0][CFG_W-1:0]   shadow_q;
  logic [NUM_SB-1:0][CFG_W-1:0]   sbConfig_q;
  logic                           done_q, done_d;
  logic                           error_q, error_d;
  logic [IDX_W-1:0]               errIndex_q, errIndex_d;
  logic                           cfgReady_q;
  logic                           accept;
  logic                           wordLegal;
  logic                           shadowWrite;
  logic                           commitNow;

  // A word is illegal when three or more sides drive, or a side has both dve and dvn set.
`ifdef SB_CFG_CHECK_EN
  logic [3:0] dveBits;
  logic [3:0] dvnBits;
  assign dveBits   = {cfg_if.cfg_word[7], cfg_if.cfg_word[5], cfg_if.cfg_word[3], cfg_if.cfg_word[1]};
  assign dvnBits   = {cfg_if.cfg_word[6], cfg_if.cfg_word[4], cfg_if.cfg_word[2], cfg_if.cfg_word[0]};
  assign wordLegal = ($countones(dveBits) < 3) && ((dveBits & dvnBits) == 4'b0000);
`else
  assign wordLegal = 1'b1;
`endif

  assign accept = cfg_if.cfg_valid && cfgReady_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_d      = done_q;
    error_d     = error_q;
    errIndex_d  = errIndex_q;
    shadowWrite = 1'b0;
    commitNow   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = LOAD;
          count_d    = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          errIndex_d = '0;
        end
      end
      LOAD: begin
        // abort takes priority, so a word offered in the same cycle is dropped
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept) begin
          if (!wordLegal) begin
            state_d    = ERROR;
            errIndex_d = count_q;
          end else begin
            shadowWrite = 1'b1;
            if (count_q == LAST) state_d = COMMIT;
            else                 count_d = count_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        commitNow = 1'b1;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      ERROR: begin
        error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shadow_q   <= '0;
      sbConfig_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      errIndex_q <= '0;
      cfgReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      error_q    <= error_d;
      errIndex_q <= errIndex_d;
      cfgReady_q <= (state_d == LOAD);
      if (shadowWrite) shadow_q[count_q] <= cfg_if.cfg_word;
      if (commitNow)   sbConfig_q <= shadow_q;
    end
  end

  assign cfg_if.cfg_ready = cfgReady_q;
  assign sb_config_o      = sbConfig_q;
  assign busy_o           = (state_q == LOAD) || (state_q == COMMIT);
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign err_index_o      = errIndex_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader: scoreboard of expected committed frames plus state checks.
// Error-path steps run only when SB_CFG_CHECK_EN is defined.
module tb_sb_config_loader;

  localparam int NUM_SB = 4;
  localparam int CFG_W  = 9;
  localparam int FW     = NUM_SB * CFG_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [FW-1:0] sbConfig;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    errIndex;

  int            errors = 0;
  int            checks = 0;
  logic [FW-1:0] expFrames[$];
  logic [FW-1:0] liveFrame;
  logic [CFG_W-1:0] stim [NUM_SB];
  int            cyc;

  sb_config_loader_if #(.CFG_W(CFG_W)) cfgIf ();

  sb_config_loader #(.NUM_SB(NUM_SB), .CFG_W(CFG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .abort_i     (abort),
    .cfg_if      (cfgIf),
    .sb_config_o (sbConfig),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .err_index_o (errIndex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [FW-1:0] stimFrame();
    return {stim[3], stim[2], stim[1], stim[0]};
  endfunction

  // Offers stim[0..n-1] in order; a word advances only when the handshake completes.
  task automatic applyStimulus(input int n, input bit toggleValid, output int cycles);
    int idx = 0;
    bit phase = 1'b1;
    bit acc;
    cycles = 0;
    while (idx < n && cycles < 20) begin
      cfgIf.cfg_word  = stim[idx];
      cfgIf.cfg_valid = toggleValid ? phase : 1'b1;
      acc   = cfgIf.cfg_valid && cfgIf.cfg_ready;
      phase = ~phase;
      tick();
      cycles++;
      if (acc) idx++;
    end
    cfgIf.cfg_valid = 1'b0;
    if (idx < n) checkOutput("accept_timeout", 64'(idx), 64'(n));
  endtask

  // Called right after the last accept edge: old frame held, then committed one edge later.
  task automatic commitCheck(input string tag);
    checkOutput({tag, "_hold"}, 64'(sbConfig), 64'(liveFrame));
    checkOutput({tag, "_done_early"}, 64'(done), 64'd0);
    tick();
    if (expFrames.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      liveFrame = expFrames.pop_front();
      checkOutput({tag, "_cfg"}, 64'(sbConfig), 64'(liveFrame));
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_ready"}, 64'(cfgIf.cfg_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfgIf.cfg_word = '0; cfgIf.cfg_valid = 1'b0;
    liveFrame = '0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_cfg",   64'(sbConfig), 64'd0);
    checkOutput("rst_ready", 64'(cfgIf.cfg_ready), 64'd0);
    checkOutput("rst_busy",  64'(busy), 64'd0);
    checkOutput("rst_done",  64'(done), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_eidx",  64'(errIndex), 64'd0);

    $display("[TB] frame 1: legal words, valid held high");
    stim = '{9'h082, 9'h0A0, 9'h122, 9'h000};
    expFrames.push_back(stimFrame());
    doStart();
    checkOutput("f1_ready", 64'(cfgIf.cfg_ready), 64'd1);
    checkOutput("f1_busy",  64'(busy), 64'd1);
    applyStimulus(4, 1'b0, cyc);
    checkOutput("f1_cycles", 64'(cyc), 64'd4);
    commitCheck("f1");

    $display("[TB] frame 2: back-to-back start, valid toggling");
    stim = '{9'h101, 9'h004, 9'h010, 9'h040};
    expFrames.push_back(stimFrame());
    doStart();
    checkOutput("f2_done_clr", 64'(done), 64'd0);
    checkOutput("f2_old_cfg",  64'(sbConfig), 64'(liveFrame));
    applyStimulus(4, 1'b1, cyc);
    checkOutput("f2_cycles", 64'(cyc), 64'd7);
    commitCheck("f2");

`ifdef SB_CFG_CHECK_EN
    $display("[TB] error path: four drivers in word 1, then dve+dvn in word 0");
    stim = '{9'h082, 9'h0AA, 9'h000, 9'h000};
    doStart();
    applyStimulus(2, 1'b0, cyc);
    checkOutput("e1_ready", 64'(cfgIf.cfg_ready), 64'd0);
    checkOutput("e1_pre",   64'(error), 64'd0);
    tick();
    checkOutput("e1_error", 64'(error), 64'd1);
    checkOutput("e1_eidx",  64'(errIndex), 64'd1);
    checkOutput("e1_cfg",   64'(sbConfig), 64'(liveFrame));
    checkOutput("e1_done",  64'(done), 64'd0);
    stim[0] = 9'h0C0;
    doStart();
    checkOutput("e2_clr",  64'(error), 64'd0);
    checkOutput("e2_eclr", 64'(errIndex), 64'd0);
    applyStimulus(1, 1'b0, cyc);
    tick();
    checkOutput("e2_error", 64'(error), 64'd1);
    checkOutput("e2_eidx",  64'(errIndex), 64'd0);
    checkOutput("e2_cfg",   64'(sbConfig), 64'(liveFrame));
`else
    $display("[TB] unchecked build: normally illegal words commit");
    stim = '{9'h082, 9'h0AA, 9'h0C0, 9'h000};
    expFrames.push_back(stimFrame());
    doStart();
    applyStimulus(4, 1'b0, cyc);
    commitCheck("nc");
    checkOutput("nc_error", 64'(error), 64'd0);
    checkOutput("nc_eidx",  64'(errIndex), 64'd0);
`endif

    $display("[TB] abort after two accepts with a word offered");
    stim = '{9'h020, 9'h008, 9'h000, 9'h000};
    doStart();
    applyStimulus(2, 1'b0, cyc);
    cfgIf.cfg_word = 9'h1FF; cfgIf.cfg_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; cfgIf.cfg_valid = 1'b0;
    checkOutput("ab_ready", 64'(cfgIf.cfg_ready), 64'd0);
    checkOutput("ab_busy",  64'(busy), 64'd0);
    checkOutput("ab_done",  64'(done), 64'd0);
    checkOutput("ab_error", 64'(error), 64'd0);
    checkOutput("ab_cfg",   64'(sbConfig), 64'(liveFrame));
    stim = '{9'h002, 9'h180, 9'h021, 9'h108};
    expFrames.push_back(stimFrame());
    doStart();
    applyStimulus(4, 1'b0, cyc);
    commitCheck("ab_next");

    $display("[TB] reset mid-load after three accepts");
    stim = '{9'h080, 9'h020, 9'h008, 9'h002};
    doStart();
    applyStimulus(3, 1'b0, cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    liveFrame = '0;
    checkOutput("mr_cfg",   64'(sbConfig), 64'd0);
    checkOutput("mr_ready", 64'(cfgIf.cfg_ready), 64'd0);
    checkOutput("mr_busy",  64'(busy), 64'd0);
    checkOutput("mr_done",  64'(done), 64'd0);
    stim = '{9'h1A0, 9'h00A, 9'h041, 9'h110};
    expFrames.push_back(stimFrame());
    doStart();
    applyStimulus(4, 1'b0, cyc);
    commitCheck("mr_next");

    checkOutput("sb_drained", 64'(expFrames.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sb_config_loader.md
Name: sb_config_loader

Overview:
Loads 9-bit switch-box configuration words (mode + per-side dve/dvn bits) from a bitstream source over a valid/ready stream. Each word is written into a shadow bank for an array of NUM_SB switch boxes. Once a full, legal frame has been received, the shadow bank is committed atomically to the live configuration outputs. The routing fabric therefore never sees a partially loaded frame. The block sits between the fabric's bitstream controller and the switch-box config_data inputs.

Parameters:
NUM_SB, 4, number of switch boxes configured per frame (>=2)
CFG_W, 9, config word width; fixed layout [8]=mode, [7:6]=N dve/dvn, [5:4]=E, [3:2]=S, [1:0]=W

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a frame load; honoured only in IDLE
abort  input  1  cancels an in-progress load; honoured only in LOAD
cfg_word  input  CFG_W  incoming configuration word
cfg_valid  input  1  cfg_word valid
cfg_ready  output  1  loader can accept cfg_word
sb_config  output  NUM_SB*CFG_W  live config; switch box i = bits [i*CFG_W +: CFG_W]
busy  output  1  high in LOAD and COMMIT
done  output  1  sticky; frame committed; cleared by next accepted start
error  output  1  sticky; illegal word rejected; cleared by next accepted start
err_index  output  $clog2(NUM_SB)  switch-box index of the rejected word

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, on ports clk and rst.
- Reset (any state, including mid-load): state=IDLE; sb_config=0 (all switch boxes high-Z); shadow=0; count=0. Outputs cfg_ready, busy, done, error and err_index are all 0.
- State machine states: IDLE, LOAD, COMMIT, ERROR.
- IDLE:
  - cfg_ready=0.
  - start=1 -> LOAD at the next edge. At that edge done, error, err_index and count are cleared.
  - abort is ignored.
- LOAD:
  - cfg_ready=1 (registered; high for the whole LOAD state).
  - Handshake: a word is accepted at an edge where cfg_valid&&cfg_ready. On acceptance, shadow[count] <= cfg_word and count increments.
  - Words are ordered: the first accepted word goes to switch box 0.
  - Illegal accepted word -> ERROR. err_index <= count. The word is not written to shadow.
  - Legal accepted word with count==NUM_SB-1 -> COMMIT.
  - abort=1 -> IDLE. Shadow contents are discarded, sb_config is unchanged, and done/error stay 0. abort wins over a simultaneous handshake; that word is dropped.
  - start is ignored.
- COMMIT: lasts one cycle, cfg_ready=0. At its closing edge: sb_config <= shadow (all boxes in the same edge), done <= 1, state -> IDLE.
  - Latency: last word accepted at edge k, then sb_config updated and done=1 at edge k+1.
- ERROR: lasts one cycle, cfg_ready=0. At its closing edge: error <= 1, state -> IDLE. sb_config keeps its previous frame.
- Legality rule (when checking is enabled): a word is illegal if it has 3 or 4 dve bits set, or if any side has both dve and dvn set. 0, 1 or 2 drivers are legal.
- count is $clog2(NUM_SB) bits wide and never wraps past NUM_SB-1 within a frame.

Optional Feature:
Macro: SB_CFG_CHECK_EN.
- Defined: the legality checker is active and the ERROR path is reachable.
- Undefined: every word is accepted as legal, ERROR is unreachable, and error/err_index stay 0. Frames always commit after NUM_SB words.

Test Plan:
- Reset then load 4 legal words 0x082, 0x0A0, 0x122, 0x000 with cfg_valid held high -> cfg_ready high for 4 cycles. sb_config = {0x000,0x122,0x0A0,0x082} one edge after the 4th accept; done=1, busy=0.
- Back-to-back: start a second frame while done=1 -> done clears at the start edge. The old sb_config is held until the new frame's COMMIT edge.
- SB_CFG_CHECK_EN defined, 2nd word 0x0AA (N,E,S,W dve = 4 drivers) -> error=1, err_index=1, sb_config unchanged. Word 0x0C0 (N dve+dvn) as word 0 -> error=1, err_index=0.
- cfg_valid toggled 1/0 every cycle -> only the valid cycles are accepted. The frame commits after exactly 4 accepts, and the words land in the correct order.
- abort asserted after 2 accepts, together with a valid word -> the word is dropped, state is IDLE, sb_config is unchanged, done=0, error=0.
- rst asserted mid-load after 3 accepts -> at the next edge sb_config=0, cfg_ready=0, busy=0. A subsequent start+4 words commits normally.
